// File: rtl/flash_cart_streamer_if.sv
// Byte stream from the cartridge loader to the cartridge RAM writer.
//   out_data  : streamed byte
//   out_addr  : byte offset of out_data within the image
//   out_valid : out_data/out_addr valid
//   out_ready : consumer takes the byte when out_valid && out_ready
// master = loader side, slave = RAM writer side.
interface flash_cart_streamer_if #(
  parameter int ADDR_W = 17
);
  logic [7:0]        out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, out_addr, out_valid, input out_ready);
  modport slave  (input out_data, out_addr, out_valid, output out_ready);
endinterface

// File: rtl/flash_cart_streamer.sv
// Cartridge loader: reads one game image from a selectable SPI flash slot
// (READ 0x03, mode 0) with a built-in serial engine and streams it byte by
// byte to the cartridge RAM writer.
//   clock, reset        : system clock, synchronous active-high reset
//   reload, index       : restart load from slot `index` (latched on reload)
//   flash_csn/sck/mosi  : SPI outputs (csn active-low, sck idles low)
//   flash_miso          : SPI data from flash
//   out (interface)     : out_data/out_addr/out_valid/out_ready byte stream
//   consumer_done       : consumer needs no more data; stop and finish
//   busy                : high in every state except DONE
//   load_done           : high in DONE
module flash_cart_streamer #(
  parameter logic [23:0] FLASH_BASE  = 24'h200000,
  parameter int          SLOT_SHIFT  = 18,
  parameter int          SLOT_BITS   = 4,
  parameter int          LOAD_BYTES  = 65536,
  parameter int          ADDR_W      = 17,
  parameter int          CLK_DIV     = 1,
  parameter int          CS_HIGH_MIN = 4,
  parameter int          TAIL_WAIT   = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reload,
  input  logic [SLOT_BITS-1:0]  index,
  output logic                  flash_csn,
  output logic                  flash_sck,
  output logic                  flash_mosi,
  input  logic                  flash_miso,
  flash_cart_streamer_if.master out,
  input  logic                  consumer_done,
  output logic                  busy,
  output logic                  load_done
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W  = $clog2(CS_HIGH_MIN + 1);
  localparam int TAIL_W = $clog2(TAIL_WAIT + 1);

  typedef enum logic [2:0] {GAP, CMD, DATA, HOLD, WAITC, TAIL, DONE} state_t;
  state_t state, state_nxt;

  logic [SLOT_BITS-1:0] slot;
  logic [31:0]          cmd_sr;   // command/address shifter; MSB drives mosi
  logic [7:0]           rx_sr;
  logic [4:0]           bit_cnt;
  logic [DIV_W-1:0]     div_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic [TAIL_W-1:0]    tail_cnt;
  logic [23:0]          slot_addr;

  logic half_end, sck_rise, sck_fall, last_bit, gap_done, tail_done;
  logic last_byte, accept, abort;

  // Address wraps mod 2**24 by the 24-bit sum.
  assign slot_addr = FLASH_BASE + (24'(slot) << SLOT_SHIFT);

  assign half_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sck_rise  = half_end && !flash_sck;
  assign sck_fall  = half_end && flash_sck;
  assign last_bit  = (state == CMD) ? (bit_cnt == 5'd31) : (bit_cnt == 5'd7);
  assign gap_done  = (gap_cnt == GAP_W'(CS_HIGH_MIN - 1));
  assign tail_done = (tail_cnt == TAIL_W'(TAIL_WAIT - 1));
  assign last_byte = (out.out_addr == ADDR_W'(LOAD_BYTES - 1));
  assign accept    = out.out_valid && out.out_ready;
  assign abort     = consumer_done && (state == CMD || state == DATA || state == HOLD);

  assign flash_mosi = cmd_sr[31];
  assign busy       = (state != DONE);
  assign load_done  = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= GAP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GAP:   if (gap_done) state_nxt = CMD;
      CMD:   if (consumer_done) state_nxt = TAIL;
             else if (sck_fall && last_bit) state_nxt = DATA;
      DATA:  if (consumer_done) state_nxt = TAIL;
             else if (sck_fall && last_bit) state_nxt = HOLD;
      HOLD:  if (consumer_done) state_nxt = TAIL;
             else if (accept) state_nxt = last_byte ? WAITC : DATA;
      WAITC: if (consumer_done) state_nxt = TAIL;
      TAIL:  if (tail_done) state_nxt = DONE;
      default: state_nxt = state;
    endcase
    if (reload) state_nxt = GAP;
  end

  always_ff @(posedge clock) begin
    if (reset || reload) begin
      flash_csn     <= 1'b1;
      flash_sck     <= 1'b0;
      cmd_sr        <= '0;
      rx_sr         <= '0;
      bit_cnt       <= '0;
      div_cnt       <= '0;
      gap_cnt       <= '0;
      tail_cnt      <= '0;
      out.out_valid <= 1'b0;
      out.out_addr  <= '0;
      if (reset) begin
        out.out_data <= '0;
        slot         <= '0;
      end else begin
        slot <= index;
      end
    end else if (abort) begin
      // A byte handshaking in this cycle is still taken by the consumer;
      // nothing further is presented.
      flash_csn     <= 1'b1;
      flash_sck     <= 1'b0;
      cmd_sr        <= '0;
      bit_cnt       <= '0;
      div_cnt       <= '0;
      out.out_valid <= 1'b0;
    end else begin
      case (state)
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_done) begin
            gap_cnt   <= '0;
            flash_csn <= 1'b0;
            cmd_sr    <= {8'h03, slot_addr};
          end
        end
        CMD, DATA: begin
          div_cnt <= half_end ? '0 : div_cnt + 1'b1;
          if (sck_rise) begin
            flash_sck <= 1'b1;
            if (state == DATA) rx_sr <= {rx_sr[6:0], flash_miso};
          end else if (sck_fall) begin
            // mosi changes only on falling sck; shifts in zeros, so it
            // reads 0 once the 32 command bits are out.
            flash_sck <= 1'b0;
            cmd_sr    <= cmd_sr << 1;
            if (last_bit) begin
              bit_cnt <= '0;
              if (state == DATA) begin
                out.out_data  <= rx_sr;
                out.out_valid <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            out.out_valid <= 1'b0;
            if (last_byte) flash_csn <= 1'b1;
            else           out.out_addr <= out.out_addr + 1'b1;
          end
        end
        TAIL: tail_cnt <= tail_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cart_streamer.sv
module tb_flash_cart_streamer;
  localparam int CS_HIGH_MIN = 4;
  localparam int TAIL_WAIT   = 255;

  logic clock = 1'b0;
  logic reset, reset3, reload, consumer_done;
  logic [3:0] index;
  logic csn, sck, mosi, busy, load_done;
  logic miso = 1'b0;
  logic csn3, sck3, mosi3, busy3, ld3;

  flash_cart_streamer_if #(.ADDR_W(4)) sif ();
  flash_cart_streamer_if #(.ADDR_W(4)) sif3 ();

  always #5 clock = ~clock;

  flash_cart_streamer #(.LOAD_BYTES(16), .ADDR_W(4), .CLK_DIV(1)) dut (
    .clock(clock), .reset(reset), .reload(reload), .index(index),
    .flash_csn(csn), .flash_sck(sck), .flash_mosi(mosi), .flash_miso(miso),
    .out(sif), .consumer_done(consumer_done), .busy(busy), .load_done(load_done));

  flash_cart_streamer #(.LOAD_BYTES(16), .ADDR_W(4), .CLK_DIV(3)) dut3 (
    .clock(clock), .reset(reset3), .reload(1'b0), .index(4'd0),
    .flash_csn(csn3), .flash_sck(sck3), .flash_mosi(mosi3), .flash_miso(1'b0),
    .out(sif3), .consumer_done(1'b0), .busy(busy3), .load_done(ld3));

  // SPI flash model: captures the 32-bit command, then returns the low byte
  // of (address + byte index), MSB first, shifted out on falling sck.
  int nbits = 0, cmd_cnt = 0, k, sck_toggles = 0;
  logic [31:0] cmd_sh = '0, last_cmd = '0;
  logic [7:0] v;
  always @(posedge csn) nbits = 0;
  always @(posedge sck) if (csn === 1'b0) begin
    if (nbits < 32) cmd_sh = {cmd_sh[30:0], mosi};
    nbits++;
    if (nbits == 32) begin last_cmd = cmd_sh; cmd_cnt++; end
  end
  always @(negedge sck) if (csn === 1'b0 && nbits >= 32) begin
    k = nbits - 32;
    v = last_cmd[7:0] + 8'(k / 8);
    miso = v[3'(7 - k % 8)];
  end
  always @(sck) sck_toggles++;

  int checks = 0, failures = 0;
  int nacc, guard, cnt, bad, tog0, run, extra, cyc, falls;
  logic stalled, stop, prev;
  logic [7:0] rec_data [16];
  logic [3:0] rec_addr [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_nbits(input int target, input string tag);
    int g = 0;
    while (nbits != target && g < 3000) begin @(negedge clock); g++; end
    check(tag, nbits, target);
  endtask

  task automatic wait_cmd(input string tag, input logic [31:0] exp);
    int c0 = cmd_cnt;
    int g = 0;
    while (cmd_cnt == c0 && g < 3000) begin @(negedge clock); g++; end
    check(tag, last_cmd, exp);
  endtask

  task automatic pulse_reload(input logic [3:0] idx);
    reload = 1'b1; index = idx;
    @(negedge clock);
    reload = 1'b0;
  endtask

  task automatic record();
    if (nacc < 16) begin rec_data[nacc] = sif.out_data; rec_addr[nacc] = sif.out_addr; end
    nacc++;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset3 = 1'b1; reload = 1'b0; index = '0; consumer_done = 1'b0;
    sif.out_ready = 1'b1; sif3.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_csn", csn, 1'b1);
    check("rst_sck_mosi", {sck, mosi}, 2'b00);
    check("rst_valid", sif.out_valid, 1'b0);
    check("rst_data_addr", {sif.out_data, sif.out_addr}, 12'h000);
    check("rst_load_done", load_done, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("busy_after_rst", busy, 1'b1);

    // Reload slot 1 during CMD bit 12 of the automatic slot-0 load.
    wait_nbits(12, "reach_cmd_bit12");
    pulse_reload(4'd1);
    check("rl1_csn_sck", {csn, sck}, 2'b10);
    check("rl1_valid_addr", {sif.out_valid, sif.out_addr}, 5'h00);
    run = 1;
    while (csn && run < 100) begin @(negedge clock); if (csn) run++; end
    check("rl1_gap_min", run >= CS_HIGH_MIN, 1'b1);
    wait_cmd("rl1_cmd", 32'h03240000);

    // Reload slot 1 again mid-DATA of byte 1.
    wait_nbits(32 + 8 + 3, "reach_byte1_bit3");
    check("pre_rl2_addr", sif.out_addr, 4'd1);
    pulse_reload(4'd1);
    check("rl2_csn_valid", {csn, sck, sif.out_valid}, 3'b100);
    check("rl2_addr", sif.out_addr, 4'd0);
    wait_cmd("rl2_cmd", 32'h03240000);
    guard = 0;
    while (!sif.out_valid && guard < 100) begin @(negedge clock); guard++; end
    check("rl2_first_byte", {sif.out_valid, sif.out_addr, sif.out_data}, {1'b1, 4'd0, 8'h00});

    // Full load of slot 3 with a 20-clock stall at byte 5.
    pulse_reload(4'd3);
    index = 4'd9;
    nacc = 0; guard = 0; stalled = 1'b0;
    while (nacc < 16 && guard < 2000) begin
      @(negedge clock); guard++;
      if (sif.out_valid && sif.out_addr == 4'd5 && !stalled) begin
        stalled = 1'b1; sif.out_ready = 1'b0; tog0 = sck_toggles; bad = 0;
        repeat (20) begin
          @(negedge clock);
          if (!(sif.out_valid === 1'b1 && sif.out_data === 8'h05 && sif.out_addr === 4'd5)) bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_sck_idle", sck_toggles - tog0, 0);
        sif.out_ready = 1'b1;
      end
      if (sif.out_valid && sif.out_ready) record();
    end
    @(negedge clock);
    check("full_count", nacc, 16);
    check("full_cmd", last_cmd, 32'h032C0000);
    check("csn_after_last", csn, 1'b1);
    check("valid_after_last", sif.out_valid, 1'b0);
    check("addr_after_last", sif.out_addr, 4'd15);
    for (int i = 0; i < 16; i++)
      check($sformatf("byte%0d", i), {rec_addr[i], rec_data[i]}, {4'(i), 8'(i)});
    repeat (10) @(negedge clock);
    check("waitc_state", {csn, busy, load_done}, 3'b110);
    consumer_done = 1'b1;
    @(negedge clock);
    consumer_done = 1'b0;
    cnt = 0;
    while (!load_done && cnt < 1000) begin @(negedge clock); cnt++; end
    check("tail_wait", cnt, TAIL_WAIT);
    check("done_busy", busy, 1'b0);

    // Early stop by the consumer on byte 7.
    pulse_reload(4'd3);
    index = 4'd5;
    nacc = 0; guard = 0; stop = 1'b0;
    while (!stop && guard < 2000) begin
      @(negedge clock); guard++;
      if (sif.out_valid && sif.out_ready) begin
        if (sif.out_addr == 4'd7) begin consumer_done = 1'b1; stop = 1'b1; end
        record();
      end
    end
    @(negedge clock);
    consumer_done = 1'b0;
    check("abort_csn_sck_valid", {csn, sck, sif.out_valid}, 3'b100);
    check("abort_idx_ignored_cmd", last_cmd, 32'h032C0000);
    cnt = 0; extra = 0;
    while (!load_done && cnt < 1000) begin
      @(negedge clock); cnt++;
      if (sif.out_valid) extra++;
    end
    check("abort_tail", cnt, TAIL_WAIT);
    check("abort_no_valid", extra, 0);
    check("abort_count", nacc, 8);
    check("abort_last_byte", {rec_addr[7], rec_data[7]}, {4'd7, 8'h07});

    // Reset while holding byte 2.
    pulse_reload(4'd3);
    guard = 0;
    while (!(sif.out_valid && sif.out_addr == 4'd2) && guard < 2000) begin
      @(negedge clock); guard++;
    end
    check("hold_byte2", {sif.out_valid, sif.out_data}, {1'b1, 8'h02});
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_csn_sck_mosi", {csn, sck, mosi}, 3'b100);
    check("mid_rst_valid_ld", {sif.out_valid, load_done}, 2'b00);
    check("mid_rst_data_addr", {sif.out_data, sif.out_addr}, 12'h000);
    reset = 1'b0;
    wait_cmd("mid_rst_cmd", 32'h03200000);

    // CLK_DIV = 3: phase lengths and command duration.
    reset3 = 1'b0;
    guard = 0;
    while (csn3 !== 1'b0 && guard < 200) begin @(negedge clock); guard++; end
    check("div3_csn_fall", csn3, 1'b0);
    cyc = 1; falls = 0; run = 1; prev = sck3; bad = 0;
    while (falls < 32 && cyc < 1000) begin
      @(negedge clock); cyc++;
      if (sck3 !== prev) begin
        if (run != 3) bad++;
        if (prev) falls++;
        prev = sck3; run = 1;
      end else run++;
    end
    check("div3_phase_len", bad, 0);
    check("div3_cmd_clocks", cyc - 1, 192);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
